fdiv: RTL
=========

FDIV -- requirements
Module: fdiv

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: req  input  1  start pulse; x and y are sampled when req=1 and busy=0.
REQ-004 SHALL have ports: x  input  32  IEEE-754 binary32 dividend.
REQ-005 SHALL have ports: y  input  32  IEEE-754 binary32 divisor.
REQ-006 SHALL have ports: busy  output  1  operation in progress.
REQ-007 SHALL have ports: valid  output  1  one-cycle pulse when rslt and flag are updated.
REQ-008 SHALL have ports: rslt  output  32  quotient x/y, registered, held until the next valid.
REQ-009 SHALL have ports: flag  output  5  {NV,DZ,OF,UF,NX} = bits [4:0], registered, held with rslt.

Function
REQ-010 SHALL use FSM states IDLE -> NORM (1 cycle) -> DIV (26 cycles) -> RND (1 cycle) -> IDLE.
- Transition IDLE->NORM on the accepted req.
REQ-011 SHALL pulse valid exactly 28 cycles after the accepted req edge, for every operand class including specials.
- busy=1 from the cycle after acceptance through the valid cycle.
- IDLE is re-entered with busy=0 on the following cycle.
REQ-012 SHALL ignore req while busy=1; no restart and no queuing. A req in the cycle after valid is accepted.
REQ-013 In NORM, SHALL form 24-bit significands (hidden bit = exponent!=0; exponent 0 treated as 1) and left-normalize subnormal significands with a leading-zero count, adjusting the exponents.
- Intermediate exponent: 10-bit signed, expx-expy+127 minus the normalization shifts.
REQ-014 In DIV, SHALL produce one quotient bit per cycle by non-restoring radix-2 iteration on a 26-bit partial remainder.
- 26 quotient bits in total.
- Sticky = remainder!=0 after the last step.
REQ-015 In RND, SHALL:
- normalize the quotient by at most 1 bit and adjust the exponent;
- denormalize by right-shift with sticky when the exponent is <=0;
- round to nearest even;
- renormalize on significand carry-out.
REQ-016 SHALL compute the sign as x[31]^y[31] for all non-NaN results.
REQ-017 SHALL apply special-case priority:
- x NaN -> x|0x00400000;
- else y NaN -> y|0x00400000 (for either NaN case, NV=1 if either input is sNaN);
- inf/inf or 0/0 -> 0xFFC00000, NV;
- inf/finite -> signed inf;
- finite/inf -> signed 0;
- nonzero finite/0 -> signed inf, DZ;
- 0/nonzero -> signed 0.
All with no other flags.
REQ-018 SHALL on overflow (rounded exponent >=255) return signed 0x7F800000 with OF|NX.
REQ-019 SHALL set UF when the result is tiny (before rounding) and inexact; an exact tiny result sets no flags.
REQ-020 SHALL set NX whenever guard|sticky is nonzero.

Reset
REQ-021 SHALL, while reset=0, asynchronously force state=IDLE, busy=0, valid=0, rslt=0, flag=0, and clear all datapath registers.
REQ-022 SHALL abandon an operation when reset is asserted mid-operation: no valid pulse, and the first req after release is accepted normally.

Configuration
REQ-023 With FDIV_SUBNORMAL_EN defined, SHALL fully support subnormal inputs and outputs per REQ-013/015/019.
REQ-024 Without FDIV_SUBNORMAL_EN:
- SHALL treat subnormal inputs as signed zero;
- SHALL flush tiny results to signed zero with UF|NX;
- the NORM leading-zero logic and the denormalizing shifter are removed;
- latency is unchanged at 28.

Verification
REQ-025 0x40C00000/0x40000000 -> rslt 0x40400000, flag 5'h00, valid exactly 28 cycles after req.
REQ-026 0x3F800000/0x40400000 -> 0x3EAAAAAB, flag 5'h01; req pulsed at cycle 10 of this operation is ignored (single valid only).
REQ-027 0x3F800000/0x00000000 -> 0x7F800000, 5'h08; 0x00000000/0x80000000 -> 0xFFC00000, 5'h10; 0x7F800001/0x3F800000 -> 0x7FC00001, 5'h10.
REQ-028 0x7F7FFFFF/0x3F000000 -> 0x7F800000, 5'h05.
REQ-029 0x00800000/0x40000000 -> 0x00400000, 5'h00 with FDIV_SUBNORMAL_EN; 0x00000000, 5'h03 without it.
REQ-030 Reset asserted at cycle 15 of an operation -> outputs 0 immediately, no valid; a new req after release gives the correct result 28 cycles later.

Source files
------------

// File: rtl/fdiv.sv
// fdiv: iterative IEEE-754 binary32 divider, fixed 28-cycle latency, round-to-nearest-even.
// Ports: clk, reset (async active-low), req, x, y in; busy, valid, rslt, flag {NV,DZ,OF,UF,NX} out.
// Define FDIV_SUBNORMAL_EN for full subnormal support; otherwise subnormals are flushed to zero.
module fdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rslt,
    output logic [4:0]  flag
);

    typedef enum logic [1:0] {IDLE, NORM, DIV, RND} state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_rslt;
    logic [4:0]  r_flag;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [23:0] r_d;
    logic [25:0] r_rem;
    logic        r_neg;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_spec;
    logic [31:0] r_spec_rslt;
    logic [4:0]  r_spec_flag;

    // operand classification
    logic [7:0]  w_ex, w_ey;
    logic [22:0] w_fx, w_fy;
    logic        w_xnan, w_ynan, w_xsnan, w_ysnan;
    logic        w_xinf, w_yinf, w_xzero, w_yzero;
    logic        w_sign;

    assign w_ex    = r_x[30:23];
    assign w_ey    = r_y[30:23];
    assign w_fx    = r_x[22:0];
    assign w_fy    = r_y[22:0];
    assign w_xnan  = (&w_ex) & (|w_fx);
    assign w_ynan  = (&w_ey) & (|w_fy);
    assign w_xsnan = w_xnan & ~w_fx[22];
    assign w_ysnan = w_ynan & ~w_fy[22];
    assign w_xinf  = (&w_ex) & ~(|w_fx);
    assign w_yinf  = (&w_ey) & ~(|w_fy);
    assign w_sign  = r_x[31] ^ r_y[31];
`ifdef FDIV_SUBNORMAL_EN
    assign w_xzero = (w_ex == 8'd0) & (w_fx == 23'd0);
    assign w_yzero = (w_ey == 8'd0) & (w_fy == 23'd0);
`else
    // subnormal inputs count as signed zero
    assign w_xzero = (w_ex == 8'd0);
    assign w_yzero = (w_ey == 8'd0);
`endif

    logic        w_spec;
    logic [31:0] w_spec_r;
    logic [4:0]  w_spec_f;

    always_comb begin
        w_spec   = 1'b1;
        w_spec_r = 32'd0;
        w_spec_f = 5'd0;
        if (w_xnan) begin
            w_spec_r = r_x | 32'h0040_0000;
            w_spec_f = {w_xsnan | w_ysnan, 4'd0};
        end else if (w_ynan) begin
            w_spec_r = r_y | 32'h0040_0000;
            w_spec_f = {w_xsnan | w_ysnan, 4'd0};
        end else if ((w_xinf & w_yinf) | (w_xzero & w_yzero)) begin
            w_spec_r = 32'hFFC0_0000;
            w_spec_f = 5'h10;
        end else if (w_xinf) begin
            w_spec_r = {w_sign, 31'h7F80_0000};
        end else if (w_yinf) begin
            w_spec_r = {w_sign, 31'd0};
        end else if (w_yzero) begin
            w_spec_r = {w_sign, 31'h7F80_0000};
            w_spec_f = 5'h08;
        end else if (w_xzero) begin
            w_spec_r = {w_sign, 31'd0};
        end else begin
            w_spec   = 1'b0;
        end
    end

    // significands and intermediate exponent (exponent 0 behaves as 1)
    logic [23:0] w_mx, w_my;
    logic [4:0]  w_lzx, w_lzy;
    logic [7:0]  w_exe, w_eye;
    logic [9:0]  w_exp;

    assign w_exe = (w_ex == 8'd0) ? 8'd1 : w_ex;
    assign w_eye = (w_ey == 8'd0) ? 8'd1 : w_ey;

`ifdef FDIV_SUBNORMAL_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++)
            if (v[i]) n = 5'(23 - i);
        return n;
    endfunction

    logic [23:0] w_rx, w_ry;
    assign w_rx  = {w_ex != 8'd0, w_fx};
    assign w_ry  = {w_ey != 8'd0, w_fy};
    assign w_lzx = lzc24(w_rx);
    assign w_lzy = lzc24(w_ry);
    assign w_mx  = w_rx << w_lzx;
    assign w_my  = w_ry << w_lzy;
`else
    assign w_lzx = 5'd0;
    assign w_lzy = 5'd0;
    assign w_mx  = {1'b1, w_fx};
    assign w_my  = {1'b1, w_fy};
`endif

    // two's complement 10-bit: ex - ey + 127 - lzx + lzy
    assign w_exp = {2'b00, w_exe} - {2'b00, w_eye} + 10'd127
                 - {5'd0, w_lzx} + {5'd0, w_lzy};

    // non-restoring step: add divisor back when last remainder was negative
    logic [25:0] w_t;
    assign w_t = r_neg ? r_rem + {2'b00, r_d} : r_rem - {2'b00, r_d};

    // rounding
    logic signed [9:0] w_e1;
    logic [23:0] w_sig, w_sig2;
    logic        w_g, w_s, w_g2, w_s2;
    logic        w_tiny, w_inc, w_nx, w_ovf;
    logic [25:0] w_fix;
    logic [9:0]  w_ebase;
    logic [32:0] w_mag;

    assign w_e1  = r_q[25] ? $signed(r_exp) : $signed(r_exp) - 10'sd1;
    assign w_sig = r_q[25] ? r_q[25:2] : r_q[24:1];
    assign w_g   = r_q[25] ? r_q[1] : r_q[0];
    // remainder is held doubled; a negative one is corrected by +2d
    assign w_fix = r_neg ? r_rem + {1'b0, r_d, 1'b0} : r_rem;
    assign w_s   = (r_q[25] & r_q[0]) | (|w_fix);
    assign w_tiny = (w_e1 <= 10'sd0);

`ifdef FDIV_SUBNORMAL_EN
    logic signed [9:0] w_shd;
    logic [4:0]  w_sh;
    logic [51:0] w_dn;
    assign w_shd  = 10'sd1 - w_e1;
    assign w_sh   = (w_shd > 10'sd27) ? 5'd27 : w_shd[4:0];
    assign w_dn   = {w_sig, w_g, 27'd0} >> w_sh;
    assign w_sig2 = w_tiny ? w_dn[51:28] : w_sig;
    assign w_g2   = w_tiny ? w_dn[27] : w_g;
    assign w_s2   = w_s | (w_tiny & (|w_dn[26:0]));
`else
    assign w_sig2 = w_sig;
    assign w_g2   = w_g;
    assign w_s2   = w_s;
`endif

    assign w_inc = w_g2 & (w_s2 | w_sig2[0]);
    assign w_nx  = w_g2 | w_s2;
    // hidden bit adds back into the exponent field; a rounding
    // carry-out renormalizes by propagating into it as well
    assign w_ebase = w_tiny ? 10'd0 : 10'(w_e1 - 10'sd1);
    assign w_mag = {w_ebase, 23'd0} + {9'd0, w_sig2} + {32'd0, w_inc};
    assign w_ovf = ~w_tiny & (w_mag[32:23] >= 10'd255);

    logic [31:0] w_rslt;
    logic [4:0]  w_flag;

    always_comb begin
        w_rslt = {r_sign, w_mag[30:0]};
        w_flag = {3'b000, w_tiny & w_nx, w_nx};
        if (r_spec) begin
            w_rslt = r_spec_rslt;
            w_flag = r_spec_flag;
        end else if (w_ovf) begin
            w_rslt = {r_sign, 31'h7F80_0000};
            w_flag = 5'h05;
`ifndef FDIV_SUBNORMAL_EN
        end else if (w_tiny) begin
            w_rslt = {r_sign, 31'd0};
            w_flag = 5'h03;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_rslt      <= 32'd0;
            r_flag      <= 5'd0;
            r_x         <= 32'd0;
            r_y         <= 32'd0;
            r_sign      <= 1'b0;
            r_exp       <= 10'd0;
            r_d         <= 24'd0;
            r_rem       <= 26'd0;
            r_neg       <= 1'b0;
            r_q         <= 26'd0;
            r_cnt       <= 5'd0;
            r_spec      <= 1'b0;
            r_spec_rslt <= 32'd0;
            r_spec_flag <= 5'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_valid) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (req && !r_busy) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_busy  <= 1'b1;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_sign      <= w_sign;
                    r_exp       <= w_exp;
                    r_d         <= w_my;
                    r_rem       <= {2'b00, w_mx};
                    r_neg       <= 1'b0;
                    r_q         <= 26'd0;
                    r_cnt       <= 5'd0;
                    r_spec      <= w_spec;
                    r_spec_rslt <= w_spec_r;
                    r_spec_flag <= w_spec_f;
                    r_state     <= DIV;
                end
                DIV: begin
                    r_rem <= {w_t[24:0], 1'b0};
                    r_neg <= w_t[25];
                    r_q   <= {r_q[24:0], ~w_t[25]};
                    if (r_cnt == 5'd25) r_state <= RND;
                    else r_cnt <= r_cnt + 5'd1;
                end
                RND: begin
                    r_rslt  <= w_rslt;
                    r_flag  <= w_flag;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign rslt  = r_rslt;
    assign flag  = r_flag;

endmodule
